cla_sub_64_pipe: RTL and testbench
==================================

// Module: cla_sub_64_pipe
// PURPOSE
//  64-bit two-stage pipelined subtractor: diff = op1 - op2, computed as op1 + ~op2 + 1 on 16-bit CLA slices.
//  Complements the registered CLA_64 adder in the datapath.
//  Adds valid/ready handshakes on both sides, so upstream stimulus/sequencers and downstream consumers can stall.
//  Sits beside the adder in the ALU datapath; produces difference plus borrow-out.
// PARAMETERS
//  WIDTH   64   operand/result width; multiple of 2*SLICE
//  SLICE   16   CLA slice width; stage 1 = low WIDTH/2 bits, stage 2 = high WIDTH/2 bits
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low; all state cleared while low
//  in_valid   in   1      op1/op2 valid this cycle
//  in_ready   out  1      stage 1 can accept; transfer when in_valid & in_ready
//  op1        in   WIDTH  minuend, unsigned or two's complement
//  op2        in   WIDTH  subtrahend
//  out_valid  out  1      diff/brout valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  diff       out  WIDTH  op1 - op2 mod 2^WIDTH
//  brout      out  1      1 when op1 < op2 unsigned (= ~carry-out of op1 + ~op2 + 1)
// BEHAVIOUR
//  - Reset (reset=0, async): s1_valid=0, s2_valid=0, out_valid=0, diff=0, brout=0; in_ready=1 once reset=1.
//  - Stage 1 on input transfer:
//    - registers low-half sum (op1[lo] + ~op2[lo] + 1) and internal carry c_mid;
//    - registers op1[hi] and ~op2[hi].
//  - Stage 2 on advance: diff[hi] = op1[hi] + ~op2[hi] + c_mid; diff[lo] passed through; brout = ~c_out.
//  - Latency: exactly 2 clock edges from input transfer to out_valid=1 with no stall. Throughput: 1 per cycle.
//  - Advance rules:
//    - s2_adv = s1_valid & (~s2_valid | out_ready)
//    - in_ready = ~s1_valid | s2_adv (combinational, no dependence on in_valid)
//  - Stall: out_valid & ~out_ready holds diff/brout/out_valid stable. The stage-1 bubble still fills; then in_ready=0.
//  - Simultaneous accept and output: when the pipe is full and out_ready=1, in, s1->s2 and out all move in the same cycle. No bubble, no data loss.
//  - diff/brout change only on s2_adv; outputs are never X after reset.
//  - Reset mid-operation: in-flight results are dropped, no output transfer; first post-reset input reaches the output at latency 2.
//  - Wrap-around: result is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  Macro SUB_OVF_FLAG_EN:
//   - Defined: adds output port ovf (1 bit), registered with diff and reset to 0.
//     ovf = (op1[MSB] != op2[MSB]) & (diff[MSB] != op1[MSB]), i.e. signed overflow.
//   - Undefined: ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package cla_pkg: WIDTH_DEF=64, SLICE_DEF=16, HALF=WIDTH_DEF/2, and typedef of the stage-1 payload record (lo_sum, c_mid, a_hi, nb_hi).
//  - Sub-module cla_slice_16: combinational 16-bit CLA with group P/G and carry-out.
//    The parent instantiates WIDTH/SLICE of them and builds a second-level lookahead carry per half.
// TESTING
//  1. Reset held 6 ns, then op1=ffff_ffff_ffff_ffff, op2=eeee_dddd_cccc_ffff -> 2 edges later diff=1111_2222_3333_0000, brout=0.
//  2. op1=0, op2=1 -> diff=ffff_ffff_ffff_ffff, brout=1. Checks borrow across the half boundary via c_mid.
//  3. op1=0000_0001_0000_0000, op2=1 -> diff=0000_0000_ffff_ffff, brout=0. Low half borrows into high half.
//  4. Back-to-back 8 vectors with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
//  5. out_ready=0 for 5 cycles mid-stream:
//     - in_ready drops after 2 accepted vectors; diff stays stable;
//     - on release, no loss or duplication.
//  6. Reset pulled low with pipe full -> out_valid=0 and diff=0 immediately (async); with SUB_OVF_FLAG_EN:
//     op1=8000_0000_0000_0000, op2=1 -> diff=7fff_ffff_ffff_ffff, ovf=1, brout=0.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared widths and the stage-1 payload record for the pipelined CLA subtractor.
package cla_pkg;
    localparam int WIDTH_DEF = 64;
    localparam int SLICE_DEF = 16;
    localparam int HALF = WIDTH_DEF / 2;
    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic            c_mid;
        logic [HALF-1:0] a_hi;
        logic [HALF-1:0] nb_hi;
    } s1_t;
endpackage

// File: rtl/cla_slice_16.sv
// cla_slice_16: combinational 16-bit carry-lookahead slice with group propagate/generate and carry-out.
module cla_slice_16
    import cla_pkg::*;
(
    input  logic [SLICE_DEF-1:0] a,
    input  logic [SLICE_DEF-1:0] b,
    input  logic                 cin,
    output logic [SLICE_DEF-1:0] s,
    output logic                 p,
    output logic                 g,
    output logic                 cout
);
    logic [SLICE_DEF-1:0] pi, gi;
    logic [SLICE_DEF:0]   c;
    always_comb begin
        pi = a ^ b;
        gi = a & b;
        c[0] = cin;
        g = 1'b0;
        for (int i = 0; i < SLICE_DEF; i++) begin
            c[i+1] = gi[i] | (pi[i] & c[i]);
            g = gi[i] | (pi[i] & g);
        end
        p = &pi;
        s = pi ^ c[SLICE_DEF-1:0];
        cout = c[SLICE_DEF];
    end
endmodule

// File: rtl/cla_sub_64_pipe.sv
// cla_sub_64_pipe: two-stage valid/ready pipelined subtractor (op1 + ~op2 + 1), low half then high half.
// Optional signed-overflow output ovf when SUB_OVF_FLAG_EN is defined.
module cla_sub_64_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             brout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int H = WIDTH / 2;
    localparam int N = H / SLICE;
    s1_t                 s1;
    logic                s1_valid, s2_adv;
    logic [1:0][H-1:0]   ha, hb, hs;
    logic [1:0]          hcin;
    logic [1:0][N:0]     c;
    logic [2*N-1:0]      sp, sg, cout_unused;
    // half 0 is the stage-1 low half, half 1 the stage-2 high half
    assign ha[0]   = op1[H-1:0];
    assign hb[0]   = ~op2[H-1:0];
    assign hcin[0] = 1'b1;
    assign ha[1]   = s1.a_hi;
    assign hb[1]   = s1.nb_hi;
    assign hcin[1] = s1.c_mid;
    for (genvar i = 0; i < 2*N; i++) begin : g_slice
        cla_slice_16 u_slice (
            .a    (ha[i/N][(i%N)*SLICE +: SLICE]),
            .b    (hb[i/N][(i%N)*SLICE +: SLICE]),
            .cin  (c[i/N][i%N]),
            .s    (hs[i/N][(i%N)*SLICE +: SLICE]),
            .p    (sp[i]),
            .g    (sg[i]),
            .cout (cout_unused[i])
        );
    end
    always_comb begin
        c = '0;
        for (int h = 0; h < 2; h++) begin
            c[h][0] = hcin[h];
            for (int k = 0; k < N; k++)
                c[h][k+1] = sg[h*N+k] | (sp[h*N+k] & c[h][k]);
        end
    end
    assign s2_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_adv;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            brout     <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_valid & in_ready)
                s1 <= '{lo_sum: hs[0], c_mid: c[0][N], a_hi: op1[WIDTH-1:H], nb_hi: ~op2[WIDTH-1:H]};
            out_valid <= s2_adv | (out_valid & ~out_ready);
            if (s2_adv) begin
                diff  <= {hs[1], s1.lo_sum};
                brout <= ~c[1][N];
            end
        end
    end
`ifdef SUB_OVF_FLAG_EN
    // nb_hi holds ~op2, so equal stored MSBs mean the operand signs differ
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ovf <= 1'b0;
        else if (s2_adv) ovf <= (s1.a_hi[H-1] == s1.nb_hi[H-1]) & (hs[1][H-1] != s1.a_hi[H-1]);
    end
`endif
endmodule

// File: tb/tb_cla_sub_64_pipe.sv
// tb_cla_sub_64_pipe: directed self-checking bench for cla_sub_64_pipe (ovf checked when SUB_OVF_FLAG_EN is defined).
module tb_cla_sub_64_pipe;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, brout;
    logic [63:0] op1 = '0, op2 = '0, diff;
`ifdef SUB_OVF_FLAG_EN
    logic        ovf;
`endif
    int checks = 0, errors = 0;
    logic [63:0] va [8];
    logic [63:0] vb [8];

    cla_sub_64_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .brout     (brout)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] d;
        d = a - b;
        chk({tag, "_diff"}, diff, d);
        chk({tag, "_brout"}, 64'(brout), 64'(a < b));
`ifdef SUB_OVF_FLAG_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'((a[63] != b[63]) && (d[63] != a[63])));
`endif
    endtask

    task automatic one(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] ed, input logic eb, input logic eo);
        in_valid = 1'b1;
        op1 = a;
        op2 = b;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_brout"}, 64'(brout), 64'(eb));
`ifdef SUB_OVF_FLAG_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) chk({tag, "_ovf_arg"}, 64'(eo), 64'd0);
`endif
    endtask

    initial begin
        int acc, oidx, cyc;
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, oidx, cyc;
        logic a_ok, f_ok;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", diff, 64'd0);
        chk("rst_brout", 64'(brout), 64'd0);
        #3 reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        one("t1", 64'hffff_ffff_ffff_ffff, 64'heeee_dddd_cccc_ffff, 64'h1111_2222_3333_0000, 1'b0, 1'b0);
        one("t2", 64'h0, 64'h1, 64'hffff_ffff_ffff_ffff, 1'b1, 1'b0);
        one("t3", 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0000_ffff_ffff, 1'b0, 1'b0);
        one("eq", 64'h1234_5678_9abc_def0, 64'h1234_5678_9abc_def0, 64'h0, 1'b0, 1'b0);
        one("min", 64'h8000_0000_0000_0000, 64'h7fff_ffff_ffff_ffff, 64'h0000_0000_0000_0001, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            va[i] = 64'h0123_4567_89ab_cdef * 64'(i + 3);
            vb[i] = 64'hfedc_ba98_7654_3210 ^ (64'(i + 1) << (i * 7));
        end
        // back-to-back stream, consumer always ready
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            if (i < 8) begin
                op1 = va[i];
                op2 = vb[i];
            end
            step();
            if (i == 0) chk("b2b_first_lat", 64'(out_valid), 64'd0);
            if (i < 8) chk($sformatf("b2b_in_ready%0d", i), 64'(in_ready), 64'd1);
            if (i >= 1 && i <= 8) begin
                chk($sformatf("b2b_valid%0d", i - 1), 64'(out_valid), 64'd1);
                chk_res($sformatf("b2b%0d", i - 1), va[i-1], vb[i-1]);
            end
            if (i == 9) chk("b2b_drained", 64'(out_valid), 64'd0);
        end

        // consumer stalls for the first 5 cycles of a new stream
        for (int i = 0; i < 8; i++) begin
            va[i] = {32'(i * 7 + 1), 32'hffff_0000 >> i};
            vb[i] = {32'(i * 9), 32'h8000_1234 << i};
        end
        acc = 0;
        oidx = 0;
        cyc = 0;
        while (oidx < 8 && cyc < 40) begin
            out_ready = (cyc >= 5);
            in_valid = (acc < 8);
            if (acc < 8) begin
                op1 = va[acc];
                op2 = vb[acc];
            end
            #1;
            if (cyc == 2) begin
                chk("stall_accepted", 64'(acc), 64'd2);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (cyc >= 2 && cyc <= 5) begin
                chk($sformatf("stall_valid_c%0d", cyc), 64'(out_valid), 64'd1);
                chk($sformatf("stall_hold_c%0d", cyc), diff, va[0] - vb[0]);
            end
            a_ok = in_valid & in_ready;
            f_ok = out_valid & out_ready;
            if (f_ok) begin
                chk_res($sformatf("stall_out%0d", oidx), va[oidx], vb[oidx]);
                oidx++;
            end
            step();
            if (a_ok) acc++;
            cyc++;
        end
        chk("stall_out_count", 64'(oidx), 64'd8);
        in_valid = 1'b0;
        step();
        chk("stall_no_dup", 64'(out_valid), 64'd0);

        // fill the pipe under stall, then reset asynchronously mid-cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        op1 = 64'h5555_5555_5555_5555;
        op2 = 64'h1;
        step();
        op1 = 64'h7;
        op2 = 64'h9;
        step();
        in_valid = 1'b0;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_valid", 64'(out_valid), 64'd1);
        #3 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_diff", diff, 64'd0);
        chk("arst_brout", 64'(brout), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_empty", 64'(out_valid), 64'd0);
        one("t6", 64'h8000_0000_0000_0000, 64'h1, 64'h7fff_ffff_ffff_ffff, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
